sample_framer: RTL and testbench

Collects the pre-emphasized 12-bit sample stream into overlapping fixed-length frames for the Hamming window stage. It sits between `preemphasis` and `hamming` in the keyword-spotter datapath. The block keeps a sliding history of the last FRAME_LEN samples. It publishes a stable frame snapshot plus a one-cycle `frame_valid` strobe: first after FRAME_LEN samples, then after every HOP further samples.

---
 rtl/sample_framer.sv | 118 +++++++++++
 tb/tb_sample_framer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_framer.sv
// Sliding-window framer: keeps the last FRAME_LEN samples and snapshots them every HOP samples.
// Latency: frame_out/frame_valid update on the edge that accepts the triggering sample.
// Backpressure: none; in_valid may be high every cycle, downstream must read frame_out within HOP samples.
module sample_framer #(
    parameter int DATA_WIDTH = 12,
    parameter int FRAME_LEN  = 128,
    parameter int HOP        = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_sample,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] frame_out [0:FRAME_LEN-1],
    output logic                  frame_valid,
    output logic [15:0]           frame_idx,
    output logic                  filling
);
    localparam int FILL_W = $clog2(FRAME_LEN) + 1;
    localparam int HOP_W  = $clog2(HOP) + 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FRAME_LEN - 1);
    localparam logic [HOP_W-1:0]  HOP_LAST  = HOP_W'(HOP - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [FILL_W-1:0]     fill_cnt;
    logic [FILL_W-1:0]     fill_cnt_nxt;
    logic [HOP_W-1:0]      hop_cnt;
    logic [HOP_W-1:0]      hop_cnt_nxt;
    logic                  emit;
    logic [DATA_WIDTH-1:0] hist         [0:FRAME_LEN-1];
    logic [DATA_WIDTH-1:0] hist_shifted [0:FRAME_LEN-1];

    // History as it looks once in_sample has been shifted in; feeds both the chain and the snapshot
    always_comb begin
        for (int i = 0; i < FRAME_LEN - 1; i++) begin
            hist_shifted[i] = hist[i+1];
        end
        hist_shifted[FRAME_LEN-1] = in_sample;
    end

    // Next state, counters and emit decision; the sample that completes a fill or a hop emits
    always_comb begin
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        hop_cnt_nxt  = hop_cnt;
        emit         = 1'b0;
        if (in_valid) begin
            case (state)
                FILL: begin
                    fill_cnt_nxt = fill_cnt + FILL_W'(1);
                    if (fill_cnt == FILL_LAST) begin
                        emit        = 1'b1;
                        state_nxt   = RUN;
                        hop_cnt_nxt = '0;
                    end
                end
                RUN: begin
                    if (hop_cnt == HOP_LAST) begin
                        emit        = 1'b1;
                        hop_cnt_nxt = '0;
                    end else begin
                        hop_cnt_nxt = hop_cnt + HOP_W'(1);
                    end
                end
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            fill_cnt <= '0;
            hop_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= fill_cnt_nxt;
            hop_cnt  <= hop_cnt_nxt;
        end
    end

    // History shift chain: oldest at index 0, holds while in_valid is low
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                hist[i] <= '0;
            end
        end else if (in_valid) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                hist[i] <= hist_shifted[i];
            end
        end
    end

    // Frame snapshot register, strobe and frame counter; snapshot only moves on emit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                frame_out[i] <= '0;
            end
            frame_valid <= 1'b0;
            frame_idx   <= '0;
        end else begin
            frame_valid <= emit;
            if (emit) begin
                for (int i = 0; i < FRAME_LEN; i++) begin
                    frame_out[i] <= hist_shifted[i];
                end
                frame_idx <= frame_idx + 16'd1;
            end
        end
    end

    assign filling = (state == FILL);

endmodule

// File: tb/tb_sample_framer.sv
module tb_sample_framer;
    localparam int DW = 12;
    localparam int FL = 128;

    typedef logic [DW-1:0]         frame_t [0:FL-1];
    typedef logic [FL*DW-1:0]      flat_t;
    typedef logic [16+FL*DW-1:0]   item_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_sample = '0;

    frame_t      fo0, fo1, fo2;
    logic        fv0, fv1, fv2;
    logic [15:0] fi0, fi1, fi2;
    logic        fil0, fil1, fil2;

    int tests = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    sample_framer #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .HOP(64)) dut_h64 (
        .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
        .frame_out(fo0), .frame_valid(fv0), .frame_idx(fi0), .filling(fil0));
    sample_framer #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .HOP(128)) dut_h128 (
        .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
        .frame_out(fo1), .frame_valid(fv1), .frame_idx(fi1), .filling(fil1));
    sample_framer #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .HOP(1)) dut_h1 (
        .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
        .frame_out(fo2), .frame_valid(fv2), .frame_idx(fi2), .filling(fil2));

    function automatic int hop_of(input int d);
        return (d == 0) ? 64 : (d == 1) ? 128 : 1;
    endfunction

    function automatic flat_t flatten(input frame_t f);
        flat_t r;
        for (int i = 0; i < FL; i++) r[i*DW +: DW] = f[i];
        return r;
    endfunction

    // Reference model: list of samples accepted since reset, emit rule from sample count
    logic [DW-1:0] m_hist [$];
    int            m_n = 0;
    flat_t         m_last [3];
    logic [15:0]   m_idx [3];
    item_t         q0 [$];
    item_t         q1 [$];
    item_t         q2 [$];

    always @(posedge clk) begin
        if (rst) begin
            m_hist.delete();
            m_n = 0;
            for (int d = 0; d < 3; d++) begin
                m_last[d] = '0;
                m_idx[d]  = '0;
            end
        end else if (in_valid) begin
            m_hist.push_back(in_sample);
            if (m_hist.size() > FL) void'(m_hist.pop_front());
            m_n++;
            if (m_n >= FL) begin
                for (int d = 0; d < 3; d++) begin
                    if (((m_n - FL) % hop_of(d)) == 0) begin
                        flat_t f;
                        for (int i = 0; i < FL; i++) f[i*DW +: DW] = m_hist[i];
                        m_idx[d]  = m_idx[d] + 16'd1;
                        m_last[d] = f;
                        if (d == 0) q0.push_back({m_idx[d], f});
                        else if (d == 1) q1.push_back({m_idx[d], f});
                        else q2.push_back({m_idx[d], f});
                    end
                end
            end
        end
    end

    task automatic cmp_frame(input string name, input int d, input flat_t got, input flat_t exp);
        tests++;
        if (got !== exp) begin
            int k = 0;
            for (int i = FL - 1; i >= 0; i--) if (got[i*DW +: DW] !== exp[i*DW +: DW]) k = i;
            failures++;
            $display("FAIL %s dut%0d: frame_out[%0d] got %0d required %0d", name, d, k,
                     got[k*DW +: DW], exp[k*DW +: DW]);
        end
    endtask

    task automatic cmp_val(input string name, input int d, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0d required %0d", name, d, got, exp);
        end
    endtask

    task automatic check(input int d, input logic fv, input logic [15:0] fi, input logic fil,
                         input flat_t ff);
        int    sz;
        item_t it;
        sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        cmp_val("pulse", d, int'(fv), (sz != 0) ? 1 : 0);
        if (sz != 0) begin
            if (d == 0) it = q0.pop_front();
            else if (d == 1) it = q1.pop_front();
            else it = q2.pop_front();
            if (fv === 1'b1) begin
                cmp_val("pulse_idx", d, int'(fi), int'(it[16+FL*DW-1 -: 16]));
                cmp_frame("pulse_frame", d, ff, it[FL*DW-1:0]);
            end
        end
        cmp_frame("held_frame", d, ff, m_last[d]);
        cmp_val("frame_idx", d, int'(fi), int'(m_idx[d]));
        cmp_val("filling", d, int'(fil), (m_n < FL) ? 1 : 0);
    endtask

    // Monitor: outputs sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            check(0, fv0, fi0, fil0, flatten(fo0));
            check(1, fv1, fi1, fil1, flatten(fo1));
            check(2, fv2, fi2, fil2, flatten(fo2));
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] s, input logic r);
        in_valid  = v;
        in_sample = s;
        rst       = r;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        cmp_val("rst_valid", 0, int'(fv0), 0);
        cmp_val("rst_idx", 0, int'(fi0), 0);
        cmp_val("rst_filling", 0, int'(fil0), 1);
        cmp_val("rst_newest", 0, 32'(fo0[FL-1]), 0);

        // contiguous ramp through the first frame
        for (int s = 1; s <= 128; s++) drive(1'b1, DW'(s), 1'b0);
        cmp_val("first_valid", 0, int'(fv0), 1);
        cmp_val("first_oldest", 0, 32'(fo0[0]), 1);
        cmp_val("first_newest", 0, 32'(fo0[FL-1]), 128);
        cmp_val("first_idx", 0, int'(fi0), 1);
        cmp_val("first_filling", 0, int'(fil0), 0);
        cmp_val("first_valid", 1, int'(fv1), 1);
        cmp_val("first_valid", 2, int'(fv2), 1);

        for (int s = 129; s <= 192; s++) drive(1'b1, DW'(s), 1'b0);
        cmp_val("second_valid", 0, int'(fv0), 1);
        cmp_val("second_oldest", 0, 32'(fo0[0]), 65);
        cmp_val("second_newest", 0, 32'(fo0[FL-1]), 192);
        cmp_val("second_idx", 0, int'(fi0), 2);
        cmp_val("nonoverlap_idx", 1, int'(fi1), 1);
        cmp_val("nonoverlap_oldest", 1, 32'(fo1[0]), 1);
        cmp_val("every_idx", 2, int'(fi2), 65);
        cmp_val("every_newest", 2, 32'(fo2[FL-1]), 192);

        // sparse continuation of the ramp with garbage on in_sample while idle
        for (int k = 0; k < 70; k++) begin
            int gap;
            gap = ((k % 16) == 0) ? 999 : $urandom_range(0, 40);
            repeat (gap) drive(1'b0, DW'($urandom_range(0, 4095)), 1'b0);
            drive(1'b1, DW'(193 + k), 1'b0);
        end

        // reset after 100 fill samples, then a fresh ramp from 500
        drive(1'b0, '0, 1'b1);
        for (int s = 500; s < 600; s++) drive(1'b1, DW'(s), 1'b0);
        drive(1'b0, '0, 1'b1);
        for (int s = 500; s <= 627; s++) drive(1'b1, DW'(s), 1'b0);
        cmp_val("restart_valid", 0, int'(fv0), 1);
        cmp_val("restart_oldest", 0, 32'(fo0[0]), 500);
        cmp_val("restart_newest", 0, 32'(fo0[FL-1]), 627);
        cmp_val("restart_idx", 0, int'(fi0), 1);
        cmp_val("restart_idx", 2, int'(fi2), 1);

        // reset and in_valid on the same edge
        drive(1'b1, DW'(12'hABC), 1'b1);
        cmp_val("rstv_valid", 0, int'(fv0), 0);
        cmp_val("rstv_idx", 0, int'(fi0), 0);
        cmp_val("rstv_filling", 0, int'(fil0), 1);
        cmp_val("rstv_newest", 0, 32'(fo0[FL-1]), 0);
        cmp_val("rstv_oldest", 2, 32'(fo2[0]), 0);

        // random traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  DW'($urandom_range(0, 4095)),
                  ($urandom_range(0, 799) == 0) ? 1'b1 : 1'b0);
        end
        repeat (3) drive(1'b0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
